// File: rtl/vga_sync_porch_if.sv
// vga_sync_porch_if: pixel stream into, and blanked VGA stream out of, the sync/porch generator.
interface vga_sync_porch_if #(parameter int VIDEO_WIDTH = 3);
  logic hsync_in, vsync_in;
  logic [VIDEO_WIDTH-1:0] red_in, grn_in, blu_in;
  logic hsync_out, vsync_out, locked;
  logic [VIDEO_WIDTH-1:0] red_out, grn_out, blu_out;
  modport master (
    output hsync_in, vsync_in, red_in, grn_in, blu_in,
    input  hsync_out, vsync_out, locked, red_out, grn_out, blu_out
  );
  modport slave (
    input  hsync_in, vsync_in, red_in, grn_in, blu_in,
    output hsync_out, vsync_out, locked, red_out, grn_out, blu_out
  );
endinterface

// File: rtl/vga_sync_porch.sv
// vga_sync_porch: recovers frame position from the active-video flags and emits blanked VGA sync/colour.
// Stage 1 decodes the sample at its recovered coordinate, stage 2 is the output register.
module vga_sync_porch #(
  parameter int VIDEO_WIDTH   = 3,
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int ACTIVE_COLS   = 640,
  parameter int ACTIVE_ROWS   = 480,
  parameter int FRONT_PORCH_H = 18,
  parameter int BACK_PORCH_H  = 50,
  parameter int FRONT_PORCH_V = 10,
  parameter int BACK_PORCH_V  = 33
) (
  input logic clock,
  input logic reset,
  vga_sync_porch_if.slave bus
);
  localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] COL_ACT  = 10'(ACTIVE_COLS);
  localparam logic [9:0] ROW_ACT  = 10'(ACTIVE_ROWS);
  localparam logic [9:0] HS_BEG   = 10'(ACTIVE_COLS + FRONT_PORCH_H);
  localparam logic [9:0] HS_END   = 10'(TOTAL_COLS - BACK_PORCH_H - 1);
  localparam logic [9:0] VS_BEG   = 10'(ACTIVE_ROWS + FRONT_PORCH_V);
  localparam logic [9:0] VS_END   = 10'(TOTAL_ROWS - BACK_PORCH_V - 1);
  typedef enum logic {UNLOCKED, LOCKED} state_t;
  state_t r_state;
  logic r_vs_prev, r1_lk, r1_hs, r1_vs;
  logic [9:0] r_col, r_row;
  logic [VIDEO_WIDTH-1:0] r1_red, r1_grn, r1_blu;
  logic w_fs, w_lk, w_act;
  logic [9:0] w_col, w_row;
  // A frame start pins the sample to (0,0); coinciding with the natural wrap yields the same value.
  always_comb begin
    w_fs  = bus.vsync_in & ~r_vs_prev;
    w_lk  = w_fs | (r_state == LOCKED);
    w_col = (w_fs || r_col == COL_LAST) ? '0 : r_col + 10'd1;
    w_row = w_fs ? '0 : r_col != COL_LAST ? r_row : r_row == ROW_LAST ? '0 : r_row + 10'd1;
    w_act = w_lk && w_col < COL_ACT && w_row < ROW_ACT;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state       <= UNLOCKED;
      r_vs_prev     <= 1'b0;
      r_col         <= '0;
      r_row         <= '0;
      r1_lk         <= 1'b0;
      r1_hs         <= 1'b1;
      r1_vs         <= 1'b1;
      r1_red        <= '0;
      r1_grn        <= '0;
      r1_blu        <= '0;
      bus.locked    <= 1'b0;
      bus.hsync_out <= 1'b1;
      bus.vsync_out <= 1'b1;
      bus.red_out   <= '0;
      bus.grn_out   <= '0;
      bus.blu_out   <= '0;
    end else begin
      r_state       <= w_lk ? LOCKED : UNLOCKED;
      r_vs_prev     <= bus.vsync_in;
      r_col         <= w_col;
      r_row         <= w_row;
      r1_lk         <= w_lk;
      r1_hs         <= !(w_lk && w_col >= HS_BEG && w_col <= HS_END);
      r1_vs         <= !(w_lk && w_row >= VS_BEG && w_row <= VS_END);
      r1_red        <= w_act ? bus.red_in : '0;
      r1_grn        <= w_act ? bus.grn_in : '0;
      r1_blu        <= w_act ? bus.blu_in : '0;
      bus.locked    <= r1_lk;
      bus.hsync_out <= r1_hs;
      bus.vsync_out <= r1_vs;
      bus.red_out   <= r1_red;
      bus.grn_out   <= r1_grn;
      bus.blu_out   <= r1_blu;
    end
endmodule

// File: tb/tb_vga_sync_porch.sv
// tb_vga_sync_porch: directed checks on a default-timing instance (line level) and a shrunken instance (frame level).
module tb_vga_sync_porch;
  logic clock = 1'b0, reset = 1'b0;
  always #5 clock = ~clock;
  vga_sync_porch_if #(.VIDEO_WIDTH(3)) bd ();
  vga_sync_porch_if #(.VIDEO_WIDTH(3)) bs ();
  vga_sync_porch u_def (.clock(clock), .reset(reset), .bus(bd));
  vga_sync_porch #(
    .TOTAL_COLS(40), .TOTAL_ROWS(20), .ACTIVE_COLS(24), .ACTIVE_ROWS(12),
    .FRONT_PORCH_H(4), .BACK_PORCH_H(6), .FRONT_PORCH_V(2), .BACK_PORCH_V(3)
  ) u_sml (.clock(clock), .reset(reset), .bus(bs));
  // hand-derived timing: instance 0 default, instance 1 shrunken
  int TC[2] = '{800, 40};
  int TR[2] = '{525, 20};
  int AC[2] = '{640, 24};
  int AR[2] = '{480, 12};
  int HB[2] = '{658, 28};
  int HE[2] = '{749, 33};
  int VB[2] = '{490, 14};
  int VE[2] = '{491, 16};
  int HW[2] = '{92, 6};
  int VW[2] = '{1600, 120};
  logic [11:0] obs_d, obs_s;
  assign obs_d = {bd.locked, bd.hsync_out, bd.vsync_out, bd.red_out, bd.grn_out, bd.blu_out};
  assign obs_s = {bs.locked, bs.hsync_out, bs.vsync_out, bs.red_out, bs.grn_out, bs.blu_out};
  int n_chk = 0, n_pass = 0;
  int scol[2], srow[2], p0c[2], p1c[2], p0r[2], p1r[2];
  bit run[2], pv[2], lk[2], p0l[2], p1l[2];
  logic [11:0] p0e[2], p1e[2];
  bit cpat = 1'b0;
  logic [2:0] cr = 3'd7, cg = 3'd7, cb = 3'd7;
  int cyc[2], t0[2], hl_cnt[2], hl_first[2], c7l[2], c7f[2], vl[2], lines[2], frames[2];
  int hbad[2], vbad[2], bad[2], last_hl_cnt[2], last_hl_first[2], last_c7l[2], last_c7f[2], last_vl[2];

  task automatic chk(input string tag, input int o, input int e);
    n_chk++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, o, e);
  endtask

  function automatic logic [11:0] expect_of(input int k, input int c, input int r, input bit l, input logic [8:0] rgb);
    bit act = l && c < AC[k] && r < AR[k];
    return {l, !(l && c >= HB[k] && c <= HE[k]), !(l && r >= VB[k] && r <= VE[k]), act ? rgb : 9'd0};
  endfunction

  task automatic drive(input int k, input logic h, input logic v, input logic [8:0] rgb);
    if (k == 0) begin
      bd.hsync_in = h;
      bd.vsync_in = v;
      {bd.red_in, bd.grn_in, bd.blu_in} = rgb;
    end else begin
      bs.hsync_in = h;
      bs.vsync_in = v;
      {bs.red_in, bs.grn_in, bs.blu_in} = rgb;
    end
  endtask

  task automatic clr();
    for (int k = 0; k < 2; k++) begin
      lk[k] = 0; pv[k] = 0; run[k] = 0;
      p0e[k] = 12'h600; p1e[k] = 12'h600;
      p0l[k] = 0; p1l[k] = 0;
    end
  endtask

  // one pixel clock on instance k: drive the next source sample, then compare the output two samples back
  task automatic step(input int k, input bit force0 = 1'b0);
    logic v;
    logic [8:0] rgb;
    logic [11:0] o;
    v = 1'b0;
    if (run[k]) begin
      scol[k] = scol[k] == TC[k] - 1 ? 0 : scol[k] + 1;
      if (scol[k] == 0) srow[k] = srow[k] == TR[k] - 1 ? 0 : srow[k] + 1;
      v = !force0 && srow[k] < AR[k];
      if (v && !pv[k]) begin
        scol[k] = 0; srow[k] = 0; lk[k] = 1;
      end
    end
    rgb = cpat ? {3'(scol[k]), 3'(srow[k]), 3'(scol[k] + srow[k])} : {cr, cg, cb};
    drive(k, run[k] && scol[k] < AC[k], v, rgb);
    pv[k] = v;
    p1e[k] = p0e[k]; p1c[k] = p0c[k]; p1r[k] = p0r[k]; p1l[k] = p0l[k];
    p0e[k] = expect_of(k, scol[k], srow[k], lk[k], rgb);
    p0c[k] = scol[k]; p0r[k] = srow[k]; p0l[k] = lk[k];
    @(posedge clock);
    #1;
    o = k ? obs_s : obs_d;
    cyc[k]++;
    if (o !== p1e[k]) bad[k]++;
    if (p1l[k]) begin
      if (p1c[k] == 0) begin
        t0[k] = cyc[k]; hl_cnt[k] = 0; hl_first[k] = -1; c7l[k] = 0;
        if (p1r[k] == 0) begin vl[k] = 0; c7f[k] = 0; end
      end
      if (!o[10]) begin
        if (hl_first[k] < 0) hl_first[k] = cyc[k] - t0[k];
        hl_cnt[k]++;
      end
      if (!o[9]) vl[k]++;
      if (o[8:0] == 9'h1FF) begin c7l[k]++; c7f[k]++; end
      if (p1c[k] == TC[k] - 1) begin
        lines[k]++;
        last_hl_cnt[k] = hl_cnt[k]; last_hl_first[k] = hl_first[k]; last_c7l[k] = c7l[k];
        if (hl_cnt[k] != HW[k] || hl_first[k] != HB[k]) hbad[k]++;
        if (p1r[k] == TR[k] - 1) begin
          frames[k]++; last_vl[k] = vl[k]; last_c7f[k] = c7f[k];
          if (vl[k] != VW[k]) vbad[k]++;
        end
      end
    end
  endtask

  task automatic start(input int k);
    run[k] = 1; scol[k] = TC[k] - 1; srow[k] = TR[k] - 1;
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 9'h1FF);
    drive(1, 1'b0, 1'b0, 9'h1FF);
    clr();
    #1 reset = 1'b1;
    #2;
    chk("rst_hsync", bd.hsync_out, 1);
    chk("rst_vsync", bd.vsync_out, 1);
    chk("rst_rgb", {bd.red_out, bd.grn_out, bd.blu_out}, 0);
    chk("rst_locked", bd.locked, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (1000) step(0);
    chk("idle_outputs", bad[0], 0);
    chk("idle_locked", bd.locked, 0);
    cr = 3'd5;
    start(0);
    step(0);
    chk("lock_t1_locked", bd.locked, 0);
    cr = 3'd7;
    step(0);
    chk("lock_t2_locked", bd.locked, 1);
    chk("lock_t2_red", bd.red_out, 5);
    repeat (2399) step(0);
    chk("lines_done", lines[0], 3);
    chk("hs_low_len", last_hl_cnt[0], 92);
    chk("hs_offset", last_hl_first[0], 658);
    chk("hs_bad_lines", hbad[0], 0);
    chk("active_px_line", last_c7l[0], 640);
    chk("def_model", bad[0], 0);
    repeat (98) step(0);
    step(0, 1'b1);
    last_hl_first[0] = -1;
    step(0);
    repeat (800) step(0);
    chk("resync_hs_offset", last_hl_first[0], 658);
    chk("resync_locked", bd.locked, 1);
    chk("resync_model", bad[0], 0);
    repeat (701) step(0);
    chk("mid_hs_low", bd.hsync_out, 0);
    reset = 1'b1;
    #2;
    chk("mid_rst_hsync", bd.hsync_out, 1);
    chk("mid_rst_locked", bd.locked, 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    clr();
    repeat (900) step(0);
    chk("post_rst_idle", bad[0], 0);
    chk("post_rst_locked", bd.locked, 0);
    start(0);
    step(0);
    chk("relock_t1", bd.locked, 0);
    step(0);
    chk("relock_t2", bd.locked, 1);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    clr();
    cpat = 1'b1;
    start(1);
    repeat (2400) step(1);
    cpat = 1'b0;
    repeat (801) step(1);
    chk("sml_frames", frames[1], 4);
    chk("sml_vs_low", last_vl[1], 120);
    chk("sml_vs_bad", vbad[1], 0);
    chk("sml_hs_len", last_hl_cnt[1], 6);
    chk("sml_hs_offset", last_hl_first[1], 28);
    chk("sml_hs_bad", hbad[1], 0);
    chk("sml_active_px", last_c7f[1], 288);
    chk("sml_model", bad[1], 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vga_sync_porch.md
VGA_SYNC_PORCH -- requirements
Module: vga_sync_porch

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- VIDEO_WIDTH, 3: bits per colour channel.
- TOTAL_COLS, 800: pixels per line, blanking included.
- TOTAL_ROWS, 525: lines per frame, blanking included.
- ACTIVE_COLS, 640: visible pixels per line.
- ACTIVE_ROWS, 480: visible lines per frame.
- FRONT_PORCH_H, 18: columns between end of active video and start of the hsync pulse.
- BACK_PORCH_H, 50: columns between end of the hsync pulse and end of line.
- FRONT_PORCH_V, 10: rows between end of active video and start of the vsync pulse.
- BACK_PORCH_V, 33: rows between end of the vsync pulse and end of frame.

REQ-002 SHALL have ports (name, direction, width, meaning):
- clock, in, 1: pixel clock; the only clock.
- reset, in, 1: asynchronous, active-high reset.
- hsync_in, in, 1: high while the input column is below ACTIVE_COLS.
- vsync_in, in, 1: high while the input row is below ACTIVE_ROWS.
- red_in, grn_in, blu_in, in, VIDEO_WIDTH each: pixel data aligned with hsync_in/vsync_in.
- hsync_out, out, 1: VGA horizontal sync, active-low pulse.
- vsync_out, out, 1: VGA vertical sync, active-low pulse.
- red_out, grn_out, blu_out, out, VIDEO_WIDTH each: blanked pixel data.
- locked, out, 1: high once frame timing is acquired.

Function
REQ-003 Frame start SHALL be any input cycle with vsync_in=1 where vsync_in was 0 on the previous cycle. That input sample is coordinate (col 0, row 0).
REQ-004 Each later input sample SHALL advance the coordinate as follows:
- col+1.
- At col=TOTAL_COLS-1, col wraps to 0 and row increments.
- At col=TOTAL_COLS-1 and row=TOTAL_ROWS-1, the coordinate wraps to (0,0).
- Counters are 10 bits; all parameters SHALL be ≤1023.
REQ-005 The state machine SHALL have two states, UNLOCKED and LOCKED.
- Reset enters UNLOCKED.
- A frame start moves UNLOCKED to LOCKED.
- LOCKED is left only by reset.
REQ-006 In LOCKED, every frame start SHALL force the coordinate to (0,0), whatever the counter value, and locked SHALL stay 1.
REQ-007 Every output SHALL be registered, with a fixed latency of 2 clocks from the corresponding input sample.
REQ-008 hsync_out SHALL be 0 when the sample's col is in [ACTIVE_COLS+FRONT_PORCH_H, TOTAL_COLS-BACK_PORCH_H-1] (default 658..749, 92 clocks). Otherwise it SHALL be 1.
REQ-009 vsync_out SHALL be 0 when the sample's row is in [ACTIVE_ROWS+FRONT_PORCH_V, TOTAL_ROWS-BACK_PORCH_V-1] (default rows 490..491). Otherwise it SHALL be 1.
REQ-010 Colour outputs SHALL equal the input sample when col<ACTIVE_COLS and row<ACTIVE_ROWS. Otherwise they SHALL be 0, regardless of the input data.
REQ-011 For samples taken while UNLOCKED, the outputs SHALL be hsync_out=1, vsync_out=1, colours 0 and locked=0.
REQ-012 locked SHALL rise in the same cycle that the first frame-start sample (0,0) appears at the outputs.
REQ-013 If a frame start coincides with the natural wrap to (0,0), the result SHALL be identical to the wrap alone, with no glitch on any output.

Reset
REQ-014 While reset=1, the block SHALL asynchronously force:
- hsync_out=1, vsync_out=1.
- red_out, grn_out, blu_out = 0.
- locked=0.
- All pipeline stages to their blank values, and the previous-vsync register to 0.
REQ-015 After reset is released, outputs SHALL stay at their REQ-014 values until a frame start propagates (REQ-011, REQ-012).

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Idle after reset: reset, then hsync_in=vsync_in=0 for 1000 clocks with red_in=7 -> hsync_out=vsync_out=1, colours 0, locked=0 throughout.
- Lock and latency: first frame start at cycle T with red_in=5 -> at T+2, red_out=5 and locked=1; at T+1, locked=0.
- Default timing over 3 frames: each line has exactly 92 consecutive clocks of hsync_out=0, starting 658 clocks after that line's col-0 output; vsync_out=0 for exactly 1600 clocks per frame, rows 490..491.
- Blanking: red_in=grn_in=blu_in=7 held constantly -> colours are 7 only for the 640x480 active samples and 0 at col 640..799 and row 480..524.
- Resync: after lock, inject a frame start at the sample with (col 100, row 200) -> that sample is output as (0,0); hsync_out falls 658 clocks later; locked stays 1.
- Mid-frame reset: assert reset at col 700, row 100 (during the hsync pulse) -> hsync_out=1 and locked=0 in the same cycle without a clock edge; after release, no sync pulse until a frame start has been seen and has propagated 2 clocks.
